// File: rtl/keypad_pkg.sv
// keypad_pkg: shared keypad geometry, scan FSM states and key-index helper.
package keypad_pkg;
  localparam int N_ROWS = 4;
  localparam int N_COLS = 4;
  localparam int N_KEYS = 16;
  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} kp_state_t;
  function automatic logic [N_KEYS-1:0] key_onehot(input logic [1:0] row, input logic [1:0] col);
    return N_KEYS'(1) << {row, col};
  endfunction
endpackage

// File: rtl/scan_tick_gen.sv
// scan_tick_gen: free-running divider emitting a one-cycle tick every SCAN_DIV clocks.
module scan_tick_gen #(
  parameter int SCAN_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int W = $clog2(SCAN_DIV);
  logic [W-1:0] cnt_q, cnt_d;
  assign tick  = cnt_q == W'(SCAN_DIV - 1);
  assign cnt_d = tick ? '0 : cnt_q + W'(1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: 4x4 keypad column scanner with press/release debounce and held one-hot key output.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_ROWS-1:0] row_in,
  output logic [N_COLS-1:0] col_out,
  output logic [N_KEYS-1:0] onehot,
  output logic              key_valid,
  output logic              key_held
);
  localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [DW-1:0] DEB_MAX = DW'(DEBOUNCE_TICKS);
  kp_state_t state_q, state_d;
  logic [N_ROWS-1:0] sync_q, rows_s_q, low;
  logic [1:0] col_q, col_d, cand_row_q, cand_row_d, low_row;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d, deb_inc;
  logic [N_KEYS-1:0] onehot_q, onehot_d;
  logic key_valid_q, key_valid_d, key_held_q, key_held_d;
  logic tick, one_low, cand_up, accept, released;

  scan_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign low     = ~rows_s_q;
  assign one_low = (low != '0) && ((low & (low - N_ROWS'(1))) == '0);
  assign low_row = low[3] ? 2'd3 : low[2] ? 2'd2 : low[1] ? 2'd1 : 2'd0;
  assign cand_up = rows_s_q[cand_row_q];
  assign deb_inc = deb_cnt_q + DW'(1);

  // accept/released are decided per state, then applied uniformly below
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    cand_row_d  = cand_row_q;
    deb_cnt_d   = deb_cnt_q;
    onehot_d    = onehot_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    accept      = 1'b0;
    released    = 1'b0;
    if (tick) begin
      case (state_q)
        SCAN:
          if (one_low) begin
            cand_row_d = low_row;
            deb_cnt_d  = DW'(1);
            state_d    = DEBOUNCE;
            accept     = DEB_MAX == DW'(1);
          end else col_d = col_q + 2'd1;
        DEBOUNCE:
          if (one_low && low_row == cand_row_q) begin
            deb_cnt_d = deb_inc;
            accept    = deb_inc == DEB_MAX;
          end else begin
            deb_cnt_d = '0;
            col_d     = col_q + 2'd1;
            state_d   = SCAN;
          end
        HELD:
          if (cand_up) begin
            deb_cnt_d = DW'(1);
            state_d   = RELEASE;
            released  = DEB_MAX == DW'(1);
          end
        RELEASE:
          if (cand_up) begin
            deb_cnt_d = deb_inc;
            released  = deb_inc == DEB_MAX;
          end else begin
            deb_cnt_d = '0;
            state_d   = HELD;
          end
        default: state_d = SCAN;
      endcase
    end
    if (accept) begin
      onehot_d    = key_onehot(low_row, col_q);
      key_valid_d = 1'b1;
      key_held_d  = 1'b1;
      deb_cnt_d   = '0;
      state_d     = HELD;
    end
    if (released) begin
      key_held_d = 1'b0;
      col_d      = col_q + 2'd1;
      deb_cnt_d  = '0;
      state_d    = SCAN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q      <= '1;
      rows_s_q    <= '1;
      state_q     <= SCAN;
      col_q       <= '0;
      cand_row_q  <= '0;
      deb_cnt_q   <= '0;
      onehot_q    <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      sync_q      <= row_in;
      rows_s_q    <= sync_q;
      state_q     <= state_d;
      col_q       <= col_d;
      cand_row_q  <= cand_row_d;
      deb_cnt_q   <= deb_cnt_d;
      onehot_q    <= onehot_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  assign col_out   = ~(N_COLS'(1) << col_q);
  assign onehot    = onehot_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;
endmodule
